// File: rtl/power_sync_pkg.sv
// Shared constants and helpers for the phase-interleaved sync generator.
// Optional spread-spectrum dithering is enabled by defining SYNC_SPREAD_EN.
package power_sync_pkg;

  localparam int         MIN_HALF  = 1;
  localparam logic [7:0] LFSR_POLY = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  // Channel k starts k/N_CH of the way through a period of p cycles.
  function automatic logic [31:0] phase_off(input int k, input logic [31:0] p, input int n_ch);
    logic [31:0] prod;
    prod = 32'(k) * p;
    return prod >> $clog2(n_ch);
  endfunction

  // One step of the right-shifting Galois LFSR for x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic [7:0] shifted;
    shifted = {1'b0, s[7:1]};
    return s[0] ? (shifted ^ LFSR_POLY) : shifted;
  endfunction

endpackage

// File: rtl/power_sync_chan.sv
// One sync channel: phase from the shared counter, high/low compare,
// glitch-free enable gating and the output flop.
module power_sync_chan
  import power_sync_pkg::*;
#(
  parameter int PW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] cnt,
  input  logic [PW-1:0] p,
  input  logic [PW-2:0] h,
  input  logic [PW-1:0] off,
  input  logic          en,
  output logic          sync
);

  logic [PW-1:0] ph_s;
  logic          raw_s;
  logic          g_r;
  logic          g_nxt_s;
  logic          started_r;
  logic          started_nxt_s;

  // Phase relative to this channel's offset, wrapped into 0..p-1.
  always_comb begin
    if (cnt >= off) begin
      ph_s = cnt - off;
    end else begin
      ph_s = cnt + p - off;
    end
    raw_s = (ph_s < {1'b0, h});
    started_nxt_s = started_r | (ph_s == '0);
  end

  // The gate only changes where it cannot cut a pulse: closes in the low
  // phase, opens exactly at the start of a high phase.
  always_comb begin
    if (!en && !raw_s) begin
      g_nxt_s = 1'b0;
    end else if (en && (ph_s == '0)) begin
      g_nxt_s = 1'b1;
    end else begin
      g_nxt_s = g_r;
    end
  end

  // After reset a channel waits for its own phase zero so no runt is emitted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      g_r       <= en;
      started_r <= 1'b0;
      sync      <= 1'b0;
    end else begin
      g_r       <= g_nxt_s;
      started_r <= started_nxt_s;
      sync      <= raw_s & g_nxt_s & started_nxt_s;
    end
  end

endmodule

// File: rtl/power_sync_gen.sv
// Multi-channel phase-interleaved sync generator: shared period counter,
// pending divider update at the wrap, optional dither under SYNC_SPREAD_EN.
module power_sync_gen
  import power_sync_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int DIV_W    = 12,
  parameter int DEF_HALF = 32,
  parameter int SS_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] half_div,
  input  logic             load,
  input  logic [N_CH-1:0]  ch_en,
  output logic [N_CH-1:0]  sync,
  output logic             period_tick,
  output logic             pending
);

  localparam int HW = DIV_W + 1;
  localparam int PW = DIV_W + 2;
  localparam logic [HW-1:0] H_ONE = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] P_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] P_TWO = {{(PW-2){1'b0}}, 2'b10};
  localparam logic [HW-1:0] DEF_H = HW'(DEF_HALF) + H_ONE;

  logic [PW-1:0]    cnt_r;
  logic [HW-1:0]    h_a_r;
  logic [HW-1:0]    pend_val_r;
  logic             pend_r;
  logic             tick_r;
  logic [HW-1:0]    h_eff_s;
  logic [PW-1:0]    p_s;
  logic             wrap_s;
  logic [DIV_W-1:0] hd_clamp_s;
  logic [HW-1:0]    pend_in_s;

`ifdef SYNC_SPREAD_EN
  logic [7:0]      lfsr_r;
  logic [7:0]      lfsr_nxt_s;
  logic [SS_W-1:0] d_r;

  assign lfsr_nxt_s = lfsr_step(lfsr_r);
  assign h_eff_s    = h_a_r + {{(HW-SS_W){1'b0}}, d_r};

  // Dither advances once per period; the first period is undithered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_r <= LFSR_SEED;
      d_r    <= '0;
    end else if (wrap_s) begin
      lfsr_r <= lfsr_nxt_s;
      d_r    <= lfsr_nxt_s[SS_W-1:0];
    end
  end
`else
  assign h_eff_s = h_a_r;
`endif

  assign p_s    = {h_eff_s, 1'b0};
  assign wrap_s = (cnt_r == p_s - P_ONE);

  // Zero would give a degenerate period, so it is clamped to the minimum.
  always_comb begin
    if (half_div < DIV_W'(MIN_HALF)) begin
      hd_clamp_s = DIV_W'(MIN_HALF);
    end else begin
      hd_clamp_s = half_div;
    end
    pend_in_s = {1'b0, hd_clamp_s} + H_ONE;
  end

  // Counter, pending divider and a tick that lines up with cnt = P-1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r      <= '0;
      h_a_r      <= DEF_H;
      pend_val_r <= DEF_H;
      pend_r     <= 1'b0;
      tick_r     <= 1'b0;
    end else begin
      if (wrap_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + P_ONE;
      end
      if (wrap_s && pend_r) begin
        h_a_r <= pend_val_r;
      end
      if (load) begin
        pend_val_r <= pend_in_s;
        pend_r     <= 1'b1;
      end else if (wrap_s) begin
        pend_r <= 1'b0;
      end
      tick_r <= !wrap_s && (cnt_r == p_s - P_TWO);
    end
  end

  assign period_tick = tick_r;
  assign pending     = pend_r;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [PW-1:0] off_s;
    assign off_s = PW'(phase_off(k, 32'(p_s), N_CH));

    power_sync_chan #(.PW(PW)) u_chan (
      .clk  (clk),
      .rst  (rst),
      .cnt  (cnt_r),
      .p    (p_s),
      .h    (h_eff_s),
      .off  (off_s),
      .en   (ch_en[k]),
      .sync (sync[k])
    );
  end

endmodule

// File: doc/power_sync_gen.md
# power_sync_gen

Multi-channel, phase-interleaved sync clock generator for the switching regulators in the power-supply section. A single period counter drives N_CH sync outputs, each at the same runtime-programmable frequency and offset by k·P/N_CH cycles. Divider updates and channel enables are glitch-free. Optional spread-spectrum dithering of the period reduces EMI peaks. Outputs go directly to the converters' SYNC pins.

## Interface
- N_CH, 2: number of sync channels. Must be a power of two, 1..8.
- DIV_W, 12: width of the half-period divider.
- DEF_HALF, 32: reset value of the half-period divider. 50 MHz / 66 = 757.6 kHz.
- SS_W, 2: dither width in bits. Used only when spread spectrum is compiled in.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-low reset.
- half_div  in  DIV_W  requested half-period minus one. H = half_div+1 cycles.
- load  in  1  one-cycle pulse that captures half_div into the pending register.
- ch_en  in  N_CH  per-channel enable.
- sync  out  N_CH  sync outputs, registered.
- period_tick  out  1  one-cycle pulse on the last cycle of each period.
- pending  out  1  high from load until the new divider is applied.

## Operation
- Active half H_a, reset value DEF_HALF+1. Period P = 2·H_a, plus 2·d when spread spectrum is enabled.
- Period counter cnt, DIV_W+2 bits, counts 0..P-1 and then wraps to 0.
- Per-channel offset: off_k = (k·P) >> log2(N_CH), truncated. Offsets are recomputed whenever P changes.
- Per-channel phase: ph_k = cnt − off_k, plus P if the result is negative.
- Raw level: raw_k = (ph_k < H_a).
- Divider update:
  - load captures half_div into the pending register. Any later load before the update overwrites it.
  - half_div = 0 is clamped to 1, so the minimum period is 4.
  - The pending value is applied on the cycle cnt = P−1, together with the new offsets, and pending clears.
  - A load on the same cycle as cnt = P−1 is applied at the following wrap, not the current one.
- Channel gating, with a per-channel gate register g_k:
  - Disable: g_k clears on the first cycle raw_k = 0 after ch_en[k] falls. A high phase in progress always completes.
  - Enable: g_k sets when ph_k = 0. The first pulse is always full width.
  - sync[k] = raw_k AND g_k.
- No pulse is ever shorter than min(H_old, H_new), including across divider updates.
- period_tick is asserted when cnt = P−1.

## Timing
- Reset values: sync = 0, period_tick = 0, pending = 0, cnt = 0, g = ch_en sampled at reset, H_a = DEF_HALF+1.
- sync is registered: the level computed from cnt at cycle t appears at cycle t+1.
- First cycle after rst deasserts is cycle 0. sync[0] goes high at cycle 1.
- Channel k first goes high at cycle 1+off_k.
- Latency from load to the new period: the remainder of the current period plus 1 cycle.
- Reset mid-operation: all state returns to its reset value on the next edge, and pending loads are discarded.

## Configuration
- SYNC_SPREAD_EN defined:
  - An 8-bit LFSR with polynomial x^8+x^6+x^5+x^4+1 and seed 0x01 steps once per wrap.
  - d = LFSR[SS_W−1:0], giving P = 2·(H_a+d). H for each channel becomes H_a+d.
  - Offsets are recomputed at each wrap from the new P.
- SYNC_SPREAD_EN undefined:
  - d = 0, no LFSR is built, and SS_W is ignored.
  - Frequency is fixed by H_a.

## Structure
- Package power_sync_pkg holds:
  - MIN_HALF = 1
  - LFSR_POLY = 8'hB8
  - LFSR_SEED = 8'h01
  - function phase_off(k, P, N_CH)
- Sub-module power_sync_chan is instantiated N_CH times. It contains the phase subtraction, compare, gate register and output flop. Its inputs are cnt, P, H, off_k and ch_en[k].
- Top level contains the counter, pending and update logic, the offset computation and the optional LFSR.

## Test plan
- N_CH=2, defaults, ch_en=2'b11:
  - sync[0] has period 66 with 33 cycles high.
  - sync[1] is its exact complement, offset 33.
  - period_tick occurs every 66 cycles.
- N_CH=4, defaults: first rising edges at cycles 1, 17, 34 and 50 (offsets 0, 16, 33, 49).
- load with half_div=9 at cnt=10:
  - pending stays high until cnt=65.
  - The next period is 20 cycles: 10 high, 10 low on sync[0].
  - No pulse shorter than 10 cycles appears.
- load with half_div=0: period 4 with 2 cycles high, i.e. the clamp is exercised.
- ch_en[0] drops at cnt=5:
  - sync[0] stays high through cnt=32, then stays low.
  - When ch_en[0] is raised again, the next rising edge is at ph=0 and the pulse is a full 33 cycles.
- rst low for 1 cycle at cnt=40: all sync outputs go to 0, pending clears, and sequencing restarts from cycle 0.
- With SYNC_SPREAD_EN defined: the sequence of periods is 66, 66+2·d1, …, with d taken from the LFSR stream starting at 0x01.
